// File: rtl/cpu4_fetch_pkg.sv
// cpu4_fetch_pkg: shared widths, NOP encoding and mode states for the fetch/loader slice.
package cpu4_fetch_pkg;
    localparam int CPU4_ADDR_W = 4;
    localparam int CPU4_DATA_W = 8;
    localparam logic [7:0] CPU4_NOP = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/cpu4_prefetch_fifo.sv
// cpu4_prefetch_fifo: 2-entry {pc, instr} buffer, head at slot 0; flush wins over push/pop.
module cpu4_prefetch_fifo
    import cpu4_fetch_pkg::*;
#(
    parameter int ADDR_W = CPU4_ADDR_W,
    parameter int DATA_W = CPU4_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_valid,
    output logic [1:0]        o_count
);
    logic [ADDR_W-1:0] r_pc [2];
    logic [DATA_W-1:0] r_instr [2];
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_slot;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);
    // Write slot accounts for the head shifting out on the same edge
    assign w_slot = r_count - {1'b0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_pc[0]    <= r_pc[1];
                r_instr[0] <= r_instr[1];
            end
            if (w_push) begin
                r_pc[w_slot[0]]    <= i_pc;
                r_instr[w_slot[0]] <= i_instr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_pc    = r_pc[0];
    assign o_instr = r_instr[0];
    assign o_valid = r_count != 2'd0;
    assign o_count = r_count;
endmodule

// File: rtl/cpu4_fetch_loader.sv
// cpu4_fetch_loader: program loader (LOAD) and prefetching instruction stream (RUN) for the 4-bit CPU.
// Define CPU4_LOAD_CSUM_EN to compute load_csum; otherwise it is tied to 0.
module cpu4_fetch_loader
    import cpu4_fetch_pkg::*;
#(
    parameter int ADDR_W = CPU4_ADDR_W,
    parameter int DATA_W = CPU4_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_stb,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] load_ptr,
    output logic [7:0]        load_csum,
    input  logic              run_en,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [1:0]        state
);
    state_t            r_state;
    state_t            w_next;
    logic              r_stb_s1;
    logic              r_stb_s2;
    logic              r_stb_d;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_load_ptr;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [1:0]        w_count;
    logic              w_wr;
    logic              w_enter_load;
    logic              w_enter_run;
    logic              w_stay_run;
    logic              w_jump;
    logic              w_flush;
    logic              w_fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // LOAD never goes straight to RUN; it must pass through IDLE
    always_comb begin
        w_next = ST_IDLE;
        w_next = load_en ? ST_LOAD : (run_en && r_state != ST_LOAD) ? ST_RUN : ST_IDLE;
    end

    assign w_enter_load = (r_state != ST_LOAD) & (w_next == ST_LOAD);
    assign w_enter_run  = (r_state != ST_RUN) & (w_next == ST_RUN);
    assign w_stay_run   = (r_state == ST_RUN) & (w_next == ST_RUN);
    assign w_jump       = w_stay_run & jump_valid;
    assign w_flush      = (r_state == ST_RUN) & ((w_next != ST_RUN) | jump_valid);
    assign w_fetch      = w_stay_run & ~jump_valid & (w_count < 2'd2);
    assign w_wr         = (r_state == ST_LOAD) & r_stb_s2 & ~r_stb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb_s1 <= 1'b0;
            r_stb_s2 <= 1'b0;
            r_stb_d  <= 1'b0;
        end else begin
            r_stb_s1 <= load_stb;
            r_stb_s2 <= r_stb_s1;
            r_stb_d  <= r_stb_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= DATA_W'(CPU4_NOP);
        end else if (w_wr) begin
            r_mem[r_load_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_load_ptr <= '0;
        else if (w_enter_load) r_load_ptr <= '0;
        else if (w_wr) r_load_ptr <= r_load_ptr + ADDR_W'(1);
    end

`ifdef CPU4_LOAD_CSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_csum <= 8'h00;
        else if (w_enter_load) r_csum <= 8'h00;
        else if (w_wr) r_csum <= r_csum ^ load_data[7:0];
    end

    assign load_csum = r_csum;
`else
    assign load_csum = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fetch_pc <= '0;
        else if (w_enter_run) r_fetch_pc <= '0;
        else if (w_jump) r_fetch_pc <= jump_addr;
        else if (w_fetch) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end

    cpu4_prefetch_fifo #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (instr_ready),
        .i_flush (w_flush),
        .i_pc    (r_fetch_pc),
        .i_instr (r_mem[r_fetch_pc]),
        .o_pc    (instr_pc),
        .o_instr (instr),
        .o_valid (instr_valid),
        .o_count (w_count)
    );

    assign load_ptr = r_load_ptr;
    assign state    = r_state;
endmodule

// File: tb/tb_cpu4_fetch_loader.sv
// tb_cpu4_fetch_loader: directed table-driven bench for the loader and prefetch stream.
module tb_cpu4_fetch_loader;
    logic       clk;
    logic       rst;
    logic       load_en;
    logic       load_stb;
    logic [7:0] load_data;
    logic [3:0] load_ptr;
    logic [7:0] load_csum;
    logic       run_en;
    logic [7:0] instr;
    logic [3:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_valid;
    logic [3:0] jump_addr;
    logic [1:0] state;

    int checks;
    int errors;

    typedef struct {
        logic       ready;
        logic       jump;
        logic [3:0] jaddr;
        logic       exp_valid;
        logic [3:0] exp_pc;
        logic [7:0] exp_instr;
    } vec_t;

    vec_t vecs [31];

    cpu4_fetch_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_stb    (load_stb),
        .load_data   (load_data),
        .load_ptr    (load_ptr),
        .load_csum   (load_csum),
        .run_en      (run_en),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_data = b;
        load_stb  = 1'b1;
        repeat (3) tick();
        load_stb  = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [7:0] csum_exp(input logic [7:0] v);
`ifdef CPU4_LOAD_CSUM_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic j, input logic [3:0] ja,
                                input logic v, input logic [3:0] pc, input logic [7:0] ins);
        vec_t t;
        t.ready = r; t.jump = j; t.jaddr = ja;
        t.exp_valid = v; t.exp_pc = pc; t.exp_instr = ins;
        return t;
    endfunction

    function automatic logic [7:0] prog(input logic [3:0] pc);
        return (pc == 4'd0) ? 8'h12 : (pc == 4'd1) ? 8'h34 : (pc == 4'd2) ? 8'h56 : 8'h00;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int k = 1; k <= 20; k++) vecs[k] = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'(k - 1), prog(4'(k - 1)));
        for (int k = 21; k <= 25; k++) vecs[k] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 8'h00);
        vecs[26] = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 8'h00);
        vecs[27] = mk(1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 8'h00);
        vecs[28] = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 8'h00);
        vecs[29] = mk(1'b1, 1'b0, 4'd0, 1'b1, 4'd10, 8'h00);
        vecs[30] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd10, 8'h00);

        rst = 1'b1; load_en = 1'b0; load_stb = 1'b0; load_data = 8'h00;
        run_en = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ptr", 32'(load_ptr), 32'd0);
        chk("rst_csum", 32'(load_csum), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);

        load_en = 1'b1;
        tick();
        chk("load_state", 32'(state), 32'd1);
        load_byte(8'h12);
        load_byte(8'h34);
        load_byte(8'h56);
        chk("load3_ptr", 32'(load_ptr), 32'd3);
        chk("load3_csum", 32'(load_csum), 32'(csum_exp(8'h70)));
        load_en = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd0);
        load_byte(8'hAA);
        chk("idle_stb_ignored", 32'(load_ptr), 32'd3);

        run_en = 1'b1;
        for (int i = 0; i < 31; i++) begin
            instr_ready = vecs[i].ready;
            jump_valid  = vecs[i].jump;
            jump_addr   = vecs[i].jaddr;
            tick();
            jump_valid  = 1'b0;
            if (i == 0) chk("run_state", 32'(state), 32'd2);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(vecs[i].exp_pc));
                chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
            end
            if (i == 25) chk("bp_count", 32'(dut.u_fifo.o_count), 32'd2);
        end

        run_en  = 1'b0;
        load_en = 1'b1;
        tick();
        chk("run2load_state", 32'(state), 32'd1);
        chk("run2load_flush", 32'(instr_valid), 32'd0);
        chk("run2load_ptr", 32'(load_ptr), 32'd0);
        for (int b = 0; b < 17; b++) load_byte(8'h80 + 8'(b));
        chk("wrap_ptr", 32'(load_ptr), 32'd1);
        chk("wrap_csum", 32'(load_csum), 32'(csum_exp(8'h90)));
        load_en = 1'b0;
        run_en  = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("wrap_idle", 32'(state), 32'd0);
        tick();
        tick();
        chk("wrap_pc0", 32'(instr_pc), 32'd0);
        chk("wrap_instr0", 32'(instr), 32'h90);
        tick();
        chk("wrap_instr1", 32'(instr), 32'h81);
        tick();
        chk("wrap_instr2", 32'(instr), 32'h82);
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);

        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_pc", 32'(instr_pc), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_ptr", 32'(load_ptr), 32'd0);
        chk("arst_csum", 32'(load_csum), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_run", 32'(state), 32'd2);
        tick();
        chk("post_rst_pc0", 32'(instr_pc), 32'd0);
        chk("post_rst_instr0", 32'(instr), 32'd0);
        tick();
        chk("post_rst_pc1", 32'(instr_pc), 32'd1);
        chk("post_rst_instr1", 32'(instr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu4_fetch_loader.md
# cpu4_fetch_loader

Program loader and instruction fetch stage sitting directly upstream of the 4-bit CPU core in `tt_um_4bit_cpu`. It holds a 16×8 program memory, fills it byte-by-byte from the pad inputs in LOAD mode, and in RUN mode streams instructions to the core decode stage. The stream goes through a 2-entry prefetch buffer with a valid/ready handshake and supports jump redirects.

## Interface
- `ADDR_W`, 4, program address width (memory depth 2^ADDR_W)
- `DATA_W`, 8, instruction width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `load_en` in 1: request LOAD mode; has priority over `run_en`
- `load_stb` in 1: pad-level byte strobe, asynchronous to `clk`
- `load_data` in DATA_W: byte to write, stable while `load_stb` is high
- `load_ptr` out ADDR_W: next write address
- `load_csum` out 8: XOR of bytes loaded since LOAD was entered
- `run_en` in 1: request RUN mode
- `instr` out DATA_W: instruction at buffer head
- `instr_pc` out ADDR_W: address of `instr`
- `instr_valid` out 1: head holds a valid instruction
- `instr_ready` in 1: core accepts the head this cycle
- `jump_valid` in 1: redirect fetch, single-cycle pulse
- `jump_addr` in ADDR_W: redirect target
- `state` out 2: IDLE=0, LOAD=1, RUN=2

## Operation
**Reset.** `rst` asynchronously forces the following:
- state IDLE
- memory all 0x00 (NOP)
- `load_ptr`, `load_csum`, `instr`, `instr_pc` = 0
- `instr_valid` = 0, buffer empty, no read in flight
- strobe synchronizer = 0

**State machine**, evaluated each edge:
- IDLE→LOAD when `load_en`.
- IDLE→RUN when `run_en & !load_en`.
- LOAD→IDLE when `!load_en`.
- RUN→LOAD when `load_en`.
- RUN→IDLE when `!run_en & !load_en`.
- Entering LOAD clears `load_ptr` and `load_csum`.
- Entering RUN sets the fetch pointer to 0.
- Leaving RUN flushes the buffer and any in-flight read; `instr_valid` is 0 from the next cycle.

**LOAD mode**
- `load_stb` passes through a 2-flop synchronizer, then rising-edge detection.
- On a detected edge: `mem[load_ptr] <= load_data`, `load_ptr++` (wraps 15→0), `load_csum ^= load_data`.
- Strobe edges outside LOAD are discarded.

**RUN mode**
- A fetch is issued when (entries + in-flight) < 2. The synchronous memory read lands in the buffer at the next edge; the fetch pointer then increments, wrapping 15→0.
- A handshake (`instr_valid & instr_ready`) pops the head.
- A push and a pop may occur on the same edge.

**Jump**
- In RUN, `jump_valid` flushes the buffer and the in-flight read, and sets the fetch pointer to `jump_addr`.
- A handshake in the same cycle still completes; the popped instruction counts as accepted.
- `jump_valid` outside RUN is ignored.

## Timing
- Load write: lands on the 3rd rising `clk` edge after the raw `load_stb` rise (2 sync + detect). `load_data` is sampled at that edge.
  - Minimum strobe high time: 3 cycles. Minimum low time: 3 cycles.
- Run start: `run_en` sampled at edge E → state RUN after E, read of address 0 issued.
  - `instr_valid`=1 with `instr_pc`=0 after E+1.
  - With `instr_ready` held 1: one instruction per cycle thereafter.
- Jump: `jump_valid` sampled at edge J → `instr_valid`=0 after J; target instruction valid after J+1.
- Backpressure: with `instr_ready`=0, the buffer fills to 2 and fetching stalls. `instr`/`instr_pc` hold stable while `instr_valid & !instr_ready`.

## Configuration
- `CPU4_LOAD_CSUM_EN` defined: `load_csum` is computed as described above.
- Undefined: checksum logic is omitted and `load_csum` is tied to 0. The port is always present.

## Structure
- Package `cpu4_fetch_pkg`: contents are
  - state enum (IDLE/LOAD/RUN)
  - `CPU4_ADDR_W`=4, `CPU4_DATA_W`=8
  - `CPU4_NOP`=8'h00
- Sub-module `cpu4_prefetch_fifo`: 2-entry {pc, instr} buffer with push, pop and flush; count output.

## Test plan
- Reset mid-RUN with `instr_valid`=1 → outputs zero immediately (asynchronously), state=0, memory reads 0x00 on next RUN.
- LOAD 3 bytes 0x12, 0x34, 0x56 → `load_ptr`=3, `load_csum`=0x70 (0 with macro undefined); RUN then yields pc0=0x12, pc1=0x34, pc2=0x56, pc3=0x00.
- Load 17 bytes → `load_ptr` wraps to 1; byte 17 overwrites address 0.
- RUN with `instr_ready`=1 for 20 cycles → `instr_pc` sequence 0..15,0..3, first valid at E+1.
- `instr_ready`=0 for 5 cycles → `instr`/`instr_pc` held and buffer count=2; ready=1 then resumes with no skipped or duplicated pc.
- `jump_valid` with `jump_addr`=9 during an accepting handshake at pc=4 → pc4 consumed, valid low one cycle, next `instr_pc`=9.
